// File: rtl/tmul_result_drain.sv
// Result drain for the tile-multiply array: credit-gated issue, fixed-latency capture, ordered FIFO output.
// Optional build macro TMUL_DRAIN_NAN_FLAG_EN adds a per-row FP16 NaN flag (out_nan) carried alongside out_data.
module tmul_result_drain #(
  parameter int unsigned LATENCY       = 15,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ROWS_PER_TILE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  logic [511:0] row_product,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         out_last,
`ifdef TMUL_DRAIN_NAN_FLAG_EN
  output logic         out_nan,
`endif
  output logic         issue_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam int unsigned DW = 512;
  localparam int unsigned LANES = 32;

  logic [LATENCY-1:0] tok;
  logic               accept;
  logic               capture;
  logic               pop;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      fifo_count_n;
  logic [CW-1:0]      inflight_count;
  logic [CW-1:0]      inflight_count_n;
  logic [CW:0]        credit_total_n;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [RW-1:0]      row_cnt;
  logic               row_is_last;

  logic [DW-1:0] mem_data [DEPTH];
  logic          mem_last [DEPTH];

  assign accept      = issue_valid & issue_ready;
  assign capture     = tok[LATENCY-1];
  assign pop         = out_valid & out_ready;
  assign row_is_last = (row_cnt == RW'(ROWS_PER_TILE - 1));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state occupancy; a capture moves a credit from in-flight to buffered.
  always_comb begin
    fifo_count_n     = fifo_count;
    inflight_count_n = inflight_count;
    case ({capture, pop})
      2'b10:   fifo_count_n = fifo_count + CW'(1);
      2'b01:   fifo_count_n = fifo_count - CW'(1);
      default: fifo_count_n = fifo_count;
    endcase
    case ({accept, capture})
      2'b10:   inflight_count_n = inflight_count + CW'(1);
      2'b01:   inflight_count_n = inflight_count - CW'(1);
      default: inflight_count_n = inflight_count;
    endcase
    credit_total_n = {1'b0, fifo_count_n} + {1'b0, inflight_count_n};
  end

  // Token pipe, counters, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok            <= '0;
      fifo_count     <= '0;
      inflight_count <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      row_cnt        <= '0;
      issue_err      <= 1'b0;
      out_valid      <= 1'b0;
      issue_ready    <= 1'b1;
    end else begin
      tok[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tok[i] <= tok[i-1];
      end
      fifo_count     <= fifo_count_n;
      inflight_count <= inflight_count_n;
      if (capture) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        row_cnt <= row_is_last ? '0 : row_cnt + RW'(1);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      issue_err   <= issue_err | (issue_valid & ~issue_ready);
      out_valid   <= (fifo_count_n != '0);
      issue_ready <= (credit_total_n < (CW + 1)'(DEPTH));
    end
  end

  // Storage is not reset; the read side is masked by out_valid.
  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      mem_data[wr_ptr] <= row_product;
      mem_last[wr_ptr] <= row_is_last;
    end
  end

  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last = out_valid & mem_last[rd_ptr];

`ifdef TMUL_DRAIN_NAN_FLAG_EN
  logic mem_nan [DEPTH];

  // FP16 NaN: all-ones exponent with a non-zero mantissa in any lane.
  function automatic logic row_has_nan(input logic [DW-1:0] r);
    logic any;
    any = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (r[16*l+10 +: 5] == 5'h1F && r[16*l +: 10] != 10'h000) begin
        any = 1'b1;
      end
    end
    return any;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      mem_nan[wr_ptr] <= row_has_nan(row_product);
    end
  end

  assign out_nan = out_valid & mem_nan[rd_ptr];
`endif

  // The credit scheme guarantees a free slot at every capture.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow_chk: assert (!(capture && !pop && fifo_count == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_tmul_result_drain.sv
// Randomized bench for tmul_result_drain against a queue-based model of issue credits and FIFO ordering.
module tb_tmul_result_drain;
  localparam int unsigned LAT  = 15;
  localparam int unsigned DEP  = 4;
  localparam int unsigned ROWS = 16;

  logic         clk;
  logic         rst_n;
  logic         issue_valid;
  logic         issue_ready;
  logic [511:0] row_product;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic         out_last;
  logic         issue_err;
`ifdef TMUL_DRAIN_NAN_FLAG_EN
  logic         out_nan;
`endif

  tmul_result_drain #(.LATENCY(LAT), .DEPTH(DEP), .ROWS_PER_TILE(ROWS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .row_product (row_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
`ifdef TMUL_DRAIN_NAN_FLAG_EN
    .out_nan     (out_nan),
`endif
    .issue_err   (issue_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pending capture cycles, buffered rows, tile row index, sticky error.
  int           cyc = 0;
  int           pend[$];
  logic [511:0] q_data[$];
  bit           q_last[$];
  bit           q_nan[$];
  bit           pop_last[$];
  int           m_row = 0;
  bit           m_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit nan_of(input logic [511:0] r);
    bit n = 0;
    for (int l = 0; l < 32; l++) begin
      logic [15:0] h;
      h = r[16*l +: 16];
      if (h[14:10] == 5'h1F && h[9:0] != 10'h0) n = 1;
    end
    return n;
  endfunction

  // Drive one cycle, advance the model across the edge, then compare at the falling edge.
  task automatic step(input bit iv, input bit ordy, input logic [511:0] rp, input bit rn);
    bit m_ready;
    issue_valid = iv;
    out_ready   = ordy;
    row_product = rp;
    rst_n       = rn;
    if (!rn) begin
      pend.delete(); q_data.delete(); q_last.delete(); q_nan.delete();
      m_row = 0;
      m_err = 0;
    end else begin
      m_ready = (q_data.size() + pend.size()) < DEP;
      if (iv && !m_ready) m_err = 1;
      if (q_data.size() > 0 && ordy) begin
        pop_last.push_back(q_last[0]);
        void'(q_data.pop_front()); void'(q_last.pop_front()); void'(q_nan.pop_front());
      end
      if (pend.size() > 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        q_data.push_back(rp);
        q_last.push_back(m_row == ROWS - 1);
        q_nan.push_back(nan_of(rp));
        m_row = (m_row + 1) % ROWS;
      end
      if (iv && m_ready) pend.push_back(cyc + LAT);
    end
    cyc++;
    @(negedge clk);
    chk("issue_ready", 512'(issue_ready), 512'((q_data.size() + pend.size()) < DEP));
    chk("out_valid", 512'(out_valid), 512'(q_data.size() != 0));
    chk("issue_err", 512'(issue_err), 512'(m_err));
    if (q_data.size() != 0) begin
      chk("out_data", out_data, q_data[0]);
      chk("out_last", 512'(out_last), 512'(q_last[0]));
`ifdef TMUL_DRAIN_NAN_FLAG_EN
      chk("out_nan", 512'(out_nan), 512'(q_nan[0]));
`endif
    end
  endtask

  logic [511:0] a5;
  logic [511:0] nanrow;

  initial begin
    a5 = {64{8'hA5}};
    nanrow = '0;
    nanrow[16*7 +: 16] = 16'h7E00;
    issue_valid = 0; out_ready = 0; row_product = '0; rst_n = 0;

    // Reset state
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    chk("rst_out_last", 512'(out_last), 512'(0));
    chk("rst_issue_ready", 512'(issue_ready), 512'(1));
    chk("rst_issue_err", 512'(issue_err), 512'(0));

    // Single issue at cycle 10, product presented at cycle 25
    for (int k = 0; k <= 26; k++) begin
      step(k == 10, k == 26, (k == 25) ? a5 : rnd512(), 1);
      if (k == 10) chk("single_ready", 512'(issue_ready), 512'(1));
      if (k == 24) chk("single_early", 512'(out_valid), 512'(0));
      if (k == 25) begin
        chk("single_valid", 512'(out_valid), 512'(1));
        chk("single_data", out_data, a5);
      end
      if (k == 26) chk("single_popped", 512'(out_valid), 512'(0));
    end

    // Fill: issue every cycle with the consumer stalled
    step(0, 0, '0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, rnd512(), 1);
      if (k == 2) chk("fill_ready_k2", 512'(issue_ready), 512'(1));
      if (k == 3) chk("fill_ready_k3", 512'(issue_ready), 512'(0));
      if (k == 4) chk("fill_err", 512'(issue_err), 512'(1));
      if (k == 19) begin
        chk("fill_valid", 512'(out_valid), 512'(1));
        chk("fill_model_count", 512'(q_data.size()), 512'(4));
      end
    end

    // Drain while still issuing; error stays sticky
    for (int k = 0; k < 40; k++) step(1, 1, rnd512(), 1);
    chk("err_sticky", 512'(issue_err), 512'(1));
    step(0, 0, '0, 0);
    chk("err_cleared", 512'(issue_err), 512'(0));

    // Reset with three rows in flight
    for (int k = 0; k < 3; k++) step(1, 0, rnd512(), 1);
    step(0, 0, rnd512(), 0);
    for (int k = 0; k < 30; k++) step(0, 1, rnd512(), 1);
    chk("midrst_valid", 512'(out_valid), 512'(0));
    chk("midrst_ready", 512'(issue_ready), 512'(1));

`ifdef TMUL_DRAIN_NAN_FLAG_EN
    for (int k = 0; k <= 15; k++) step(k == 0, 0, (k == 15) ? nanrow : 512'(0), 1);
    chk("nan_lane7", 512'(out_nan), 512'(1));
    step(0, 1, '0, 1);
`endif

    // Tile boundary: only the 16th row of a tile is flagged
    step(0, 0, '0, 0);
    pop_last.delete();
    for (int k = 0; k < 130; k++) step(1, 1, rnd512(), 1);
    chk("last_count", 512'(pop_last.size() >= 17), 512'(1));
    if (pop_last.size() >= 17) begin
      chk("last_row15", 512'(pop_last[14]), 512'(0));
      chk("last_row16", 512'(pop_last[15]), 512'(1));
      chk("last_row17", 512'(pop_last[16]), 512'(0));
    end

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 50, rnd512(),
           $urandom_range(399, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
